// File: rtl/i2c_slave_block.sv
// rtl/i2c_slave_block.sv - I2C target engine: START/STOP detect, 7-bit address match, write strobe, stretched read handshake
module i2c_slave_block #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_full_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       rw_o,
    output logic       nack_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK
    } state_t;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       byte_done, byte_done_n;
    logic       sda_oe_n, scl_oe_n, rw_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, tx_ready_n, start_n, stop_n, nack_n;

    logic scl_meta, scl_sync, scl_hist;
    logic sda_meta, sda_sync, sda_hist;

    // Synchronizers are left unreset so a reset never fabricates a bus edge.
    always_ff @(posedge i2c_core_clock_i) begin
        scl_meta <= scl_i;
        scl_sync <= scl_meta;
        scl_hist <= scl_sync;
        sda_meta <= sda_i;
        sda_sync <= sda_meta;
        sda_hist <= sda_sync;
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_sync & ~scl_hist;
    assign scl_fall  = ~scl_sync & scl_hist;
    // SCL must be high in both samples so an SDA change coincident with an SCL edge is not a condition.
    assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
    assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;

    assign busy_o = (state != IDLE);

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        byte_done_n = byte_done;
        sda_oe_n    = sda_oe_o;
        scl_oe_n    = scl_oe_o;
        rx_data_n   = rx_data_o;
        rw_n        = rw_o;
        rx_valid_n  = 1'b0;
        tx_ready_n  = 1'b0;
        start_n     = 1'b0;
        stop_n      = 1'b0;
        nack_n      = 1'b0;
        if (start_det) begin
            state_n     = ADDR;
            bit_cnt_n   = 3'd0;
            byte_done_n = 1'b0;
            sda_oe_n    = 1'b0;
            scl_oe_n    = 1'b0;
            start_n     = 1'b1;
        end else if (stop_det) begin
            state_n     = IDLE;
            byte_done_n = 1'b0;
            sda_oe_n    = 1'b0;
            scl_oe_n    = 1'b0;
            stop_n      = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_sync};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_n = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_n = 1'b0;
                        if (state == ADDR) begin
                            if (shift[7:1] == SLAVE_ADDR) begin
                                rw_n     = shift[0];
                                sda_oe_n = 1'b1;
                                state_n  = ADDR_ACK;
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (!rx_full_i) begin
                            rx_data_n  = shift;
                            rx_valid_n = 1'b1;
                            sda_oe_n   = 1'b1;
                            state_n    = WR_ACK;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 3'd0;
                        state_n   = rw_o ? RD_LOAD : WR_DATA;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 3'd0;
                        state_n   = WR_DATA;
                    end
                end
                RD_LOAD: begin
                    // SCL is low here, so stretching or driving the first bit cannot glitch the bus.
                    if (tx_valid_i) begin
                        shift_n    = tx_data_i;
                        tx_ready_n = 1'b1;
                        sda_oe_n   = ~tx_data_i[7];
                        scl_oe_n   = 1'b0;
                        bit_cnt_n  = 3'd0;
                        state_n    = RD_DATA;
                    end else begin
                        scl_oe_n = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 3'd0;
                            state_n   = RD_ACK;
                        end else begin
                            shift_n   = {shift[6:0], 1'b0};
                            sda_oe_n  = ~shift[6];
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_sync) begin
                        nack_n  = 1'b1;
                        state_n = IDLE;
                    end else if (scl_fall) begin
                        state_n = RD_LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_i) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            byte_done  <= 1'b0;
            sda_oe_o   <= 1'b0;
            scl_oe_o   <= 1'b0;
            rx_data_o  <= 8'h00;
            rw_o       <= 1'b0;
            rx_valid_o <= 1'b0;
            tx_ready_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            nack_o     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            byte_done  <= byte_done_n;
            sda_oe_o   <= sda_oe_n;
            scl_oe_o   <= scl_oe_n;
            rx_data_o  <= rx_data_n;
            rw_o       <= rw_n;
            rx_valid_o <= rx_valid_n;
            tx_ready_o <= tx_ready_n;
            start_o    <= start_n;
            stop_o     <= stop_n;
            nack_o     <= nack_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_block.sv
// tb/tb_i2c_slave_block.sv - bench for i2c_slave_block with bus-level master and transaction reference model
module tb_i2c_slave_block;

    localparam int H   = 12;
    localparam int Q   = 6;
    localparam int TMO = 4000;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       scl_m    = 1'b1;
    logic       sda_m    = 1'b1;
    logic       rx_full  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;

    logic       scl_oe_o, sda_oe_o, rx_valid_o, tx_ready_o;
    logic       start_o, stop_o, rw_o, nack_o, busy_o;
    logic [7:0] rx_data_o;
    logic       scl_line, sda_line;

    assign scl_line = scl_m & ~scl_oe_o;
    assign sda_line = sda_m & ~sda_oe_o;

    always #5 clk = ~clk;

    i2c_slave_block dut (
        .i2c_core_clock_i(clk),
        .reset_i         (rst),
        .scl_i           (scl_line),
        .sda_i           (sda_line),
        .scl_oe_o        (scl_oe_o),
        .sda_oe_o        (sda_oe_o),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_full_i       (rx_full),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready_o),
        .start_o         (start_o),
        .stop_o          (stop_o),
        .rw_o            (rw_o),
        .nack_o          (nack_o),
        .busy_o          (busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    int rx_cnt = 0, txr_cnt = 0, st_cnt = 0, sp_cnt = 0, nk_cnt = 0;
    int sdaoe_cyc = 0, scloe_cyc = 0, wide_cnt = 0;
    logic [7:0] obs_rx [256];
    logic p_rxv = 1'b0, p_txr = 1'b0, p_st = 1'b0, p_sp = 1'b0, p_nk = 1'b0;

    always @(negedge clk) begin
        if (rx_valid_o) begin
            obs_rx[rx_cnt % 256] <= rx_data_o;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_ready_o) txr_cnt <= txr_cnt + 1;
        if (start_o)    st_cnt  <= st_cnt + 1;
        if (stop_o)     sp_cnt  <= sp_cnt + 1;
        if (nack_o)     nk_cnt  <= nk_cnt + 1;
        if (sda_oe_o)   sdaoe_cyc <= sdaoe_cyc + 1;
        if (scl_oe_o)   scloe_cyc <= scloe_cyc + 1;
        if ((rx_valid_o && p_rxv) || (tx_ready_o && p_txr) || (start_o && p_st) ||
            (stop_o && p_sp) || (nack_o && p_nk))
            wide_cnt <= wide_cnt + 1;
        p_rxv <= rx_valid_o;
        p_txr <= tx_ready_o;
        p_st  <= start_o;
        p_sp  <= stop_o;
        p_nk  <= nack_o;
    end

    logic [7:0] tx_bytes [64];
    int         tx_dly [64];
    int         tx_wr = 0;
    int         tx_rd = 0;

    initial begin : feeder
        int n;
        forever begin
            @(negedge clk);
            if (tx_rd != tx_wr) begin
                if (tx_dly[tx_rd % 64] > 0) begin
                    n = 0;
                    while (scl_oe_o !== 1'b1 && n < TMO) begin
                        @(negedge clk);
                        n++;
                    end
                    repeat (tx_dly[tx_rd % 64]) @(negedge clk);
                end
                tx_data  = tx_bytes[tx_rd % 64];
                tx_valid = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (tx_ready_o !== 1'b1 && n < TMO);
                tx_valid = 1'b0;
                tx_rd++;
            end
        end
    end

    logic [7:0] exp_rx [$];
    int         obs_rd = 0;
    logic [7:0] wdata [8];
    logic       wfull [8];
    logic [7:0] rdata [8];
    int         rdly [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high;
        int n;
        n = 0;
        while (scl_line !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("scl_release_timeout", 32'(scl_line), 32'd1);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        cyc(Q);
        scl_m = 1'b1;
        wait_scl_high();
        cyc(H);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic sample_bit(output logic b);
        sda_m = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        wait_scl_high();
        cyc(H / 2);
        b = sda_line;
        cyc(H / 2);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sample_bit(v);
        ack = ~v;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            sample_bit(v);
            b[i] = v;
        end
        send_bit(~ack);
    endtask

    task automatic i2c_start;
        sda_m = 1'b0;
        cyc(H);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_rep_start;
        sda_m = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        wait_scl_high();
        cyc(H);
        sda_m = 1'b0;
        cyc(H);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b1;
        wait_scl_high();
        cyc(H);
        sda_m = 1'b1;
        cyc(H);
    endtask

    task automatic write_body(input logic [7:0] ab, input int n, input string tag);
        logic a, alive, exp_ack;
        alive = (ab[7:1] == 7'h3C) && !ab[0];
        write_byte(ab, a);
        check($sformatf("%s_addr_ack", tag), 32'(a), 32'(alive));
        if (!alive) check($sformatf("%s_addr_busy", tag), 32'(busy_o), 32'd0);
        else        check($sformatf("%s_rw", tag), 32'(rw_o), 32'd0);
        for (int i = 0; i < n; i++) begin
            rx_full = wfull[i];
            write_byte(wdata[i], a);
            rx_full = 1'b0;
            exp_ack = alive && !wfull[i];
            check($sformatf("%s_d%0d_ack", tag, i), 32'(a), 32'(exp_ack));
            if (exp_ack) exp_rx.push_back(wdata[i]);
            else         alive = 1'b0;
        end
    endtask

    task automatic check_rx(input string tag);
        int k;
        k = rx_cnt - obs_rd;
        check($sformatf("%s_rx_count", tag), 32'(k), 32'(exp_rx.size()));
        for (int i = 0; i < k && exp_rx.size() > 0; i++) begin
            check($sformatf("%s_rx_byte%0d", tag, i), 32'(obs_rx[obs_rd % 256]), 32'(exp_rx.pop_front()));
            obs_rd++;
        end
        obs_rd = rx_cnt;
        exp_rx.delete();
    endtask

    task automatic read_body(input int n, input string tag);
        logic a;
        logic [7:0] b;
        int s0, lo, hi;
        lo = 0;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            tx_bytes[tx_wr % 64] = rdata[i];
            tx_dly[tx_wr % 64]   = rdly[i];
            tx_wr++;
            lo += rdly[i];
            hi += (rdly[i] > 0) ? rdly[i] + 2 : 0;
        end
        s0 = scloe_cyc;
        write_byte(8'h79, a);
        check($sformatf("%s_addr_ack", tag), 32'(a), 32'd1);
        check($sformatf("%s_rw", tag), 32'(rw_o), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, b);
            check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(rdata[i]));
        end
        check($sformatf("%s_stretch_window", tag),
              32'((scloe_cyc - s0) >= lo && (scloe_cyc - s0) <= hi), 32'd1);
    endtask

    task automatic do_write(input logic [7:0] ab, input int n, input string tag);
        int st0, sp0, oe0;
        st0 = st_cnt;
        sp0 = sp_cnt;
        oe0 = sdaoe_cyc;
        i2c_start();
        write_body(ab, n, tag);
        i2c_stop();
        cyc(4);
        check($sformatf("%s_busy_end", tag), 32'(busy_o), 32'd0);
        check($sformatf("%s_starts", tag), 32'(st_cnt - st0), 32'd1);
        check($sformatf("%s_stops", tag), 32'(sp_cnt - sp0), 32'd1);
        if (ab[7:1] != 7'h3C) check($sformatf("%s_sda_quiet", tag), 32'(sdaoe_cyc - oe0), 32'd0);
        check_rx(tag);
    endtask

    task automatic do_read(input int n, input string tag);
        int tr0, nk0;
        tr0 = txr_cnt;
        nk0 = nk_cnt;
        i2c_start();
        read_body(n, tag);
        i2c_stop();
        cyc(4);
        check($sformatf("%s_tx_ready", tag), 32'(txr_cnt - tr0), 32'(n));
        check($sformatf("%s_nack", tag), 32'(nk_cnt - nk0), 32'd1);
        check($sformatf("%s_busy_end", tag), 32'(busy_o), 32'd0);
    endtask

    initial begin : main
        logic a;
        logic [7:0] b;
        int st0, nk0, oe0, n;

        cyc(6);
        check("reset_outputs",
              32'({scl_oe_o, sda_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
                   start_o, stop_o, rw_o, nack_o, busy_o}), 32'd0);
        rst = 1'b0;
        cyc(10);

        wdata[0] = 8'hA5; wfull[0] = 1'b0;
        wdata[1] = 8'h5A; wfull[1] = 1'b0;
        do_write(8'h78, 2, "wr");

        wdata[0] = 8'h11; wfull[0] = 1'b0;
        wdata[1] = 8'h22; wfull[1] = 1'b0;
        do_write(8'h7A, 2, "mismatch");

        wdata[0] = 8'h99; wfull[0] = 1'b0;
        do_write(8'h00, 1, "gcall");

        rdata[0] = 8'hC3; rdly[0] = 50;
        rdata[1] = 8'h3C; rdly[1] = 0;
        do_read(2, "rd_stretch");

        wdata[0] = 8'h33; wfull[0] = 1'b0;
        wdata[1] = 8'h44; wfull[1] = 1'b1;
        do_write(8'h78, 2, "rxfull");

        st0 = st_cnt;
        nk0 = nk_cnt;
        i2c_start();
        wdata[0] = 8'h10; wfull[0] = 1'b0;
        write_body(8'h78, 1, "rs_w");
        i2c_rep_start();
        rdata[0] = 8'($urandom_range(0, 255)); rdly[0] = 0;
        read_body(1, "rs_r");
        i2c_stop();
        cyc(4);
        check("rs_starts", 32'(st_cnt - st0), 32'd2);
        check("rs_nack", 32'(nk_cnt - nk0), 32'd1);
        check("rs_busy_end", 32'(busy_o), 32'd0);
        check_rx("rs");

        tx_bytes[tx_wr % 64] = 8'h3C;
        tx_dly[tx_wr % 64]   = 0;
        tx_wr++;
        i2c_start();
        write_byte(8'h79, a);
        check("rst_addr_ack", 32'(a), 32'd1);
        cyc(1);
        check("rst_sda_driven", 32'(sda_oe_o), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_sda_release", 32'(sda_oe_o), 32'd0);
        check("rst_scl_release", 32'(scl_oe_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        oe0 = sdaoe_cyc;
        read_byte(1'b0, b);
        check("rst_bus_idle", 32'(b), 32'hFF);
        check("rst_sda_quiet", 32'(sdaoe_cyc - oe0), 32'd0);
        check("rst_still_idle", 32'(busy_o), 32'd0);
        i2c_stop();
        cyc(4);
        wdata[0] = 8'hE7; wfull[0] = 1'b0;
        do_write(8'h78, 1, "rst_recover");

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                wdata[i] = 8'($urandom_range(0, 255));
                wfull[i] = ($urandom_range(0, 4) == 0);
            end
            b = ($urandom_range(0, 1) == 1) ? 8'h78 : {7'($urandom_range(0, 127)), 1'b0};
            do_write(b, n, $sformatf("rnd_w%0d", t));
        end

        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) begin
                rdata[i] = 8'($urandom_range(0, 255));
                rdly[i]  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
            end
            do_read(n, $sformatf("rnd_r%0d", t));
        end

        check("pulse_width", 32'(wide_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
